// File: rtl/mult_partial_result_accumulator.sv
// Recombines fracturable-multiplier partial vectors into lane values and accumulates them
// per frame, presenting per-frame totals on a valid/ready output.
module mult_partial_result_accumulator #(
  parameter int ACC_W   = 48,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_first,
  input  logic               in_last,
  input  logic [1:0]         mode,
  input  logic               a_sign,
  input  logic               b_sign,
  input  logic [31:0]        result_0,
  input  logic [31:0]        result_1,
  input  logic [1:0]         result_SIDM_carry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_lane0,
  output logic [ACC_W-1:0]   out_lane1,
  output logic [COUNT_W-1:0] out_count,
  output logic               err_sticky
);

  localparam logic [1:0] MODE_16X16    = 2'b00;
  localparam logic [1:0] MODE_SUM_16X8 = 2'b01;
  localparam logic [1:0] MODE_DUAL_8X4 = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL  = 2'b11;

  // Combine stage signals
  logic             sext;
  logic [31:0]      sum_00;
  logic [32:0]      sum_01;
  logic [20:0]      sum_lo;
  logic [12:0]      sum_hi;
  logic [ACC_W-1:0] c_v0, c_v1;

  // S1 registers
  logic             s1_valid, s1_first, s1_last;
  logic [1:0]       s1_mode;
  logic [ACC_W-1:0] s1_v0, s1_v1;

  // S2 open-frame state
  logic               frame_open;
  logic [1:0]         frame_mode;
  logic [ACC_W-1:0]   acc0, acc1;
  logic [COUNT_W-1:0] count;

  logic               s1_advance, in_accept;
  logic               s2_mismatch, s2_take, s2_drop, s2_stall, s2_start;
  logic [ACC_W-1:0]   next_acc0, next_acc1;
  logic [COUNT_W-1:0] next_count;

  // NOTE: every output of this block is given a default first so no path infers a latch.
  always_comb begin
    sext   = a_sign | b_sign;
    sum_00 = result_0 + result_1;
    sum_01 = {result_SIDM_carry[1], result_0} + {1'b0, result_1};
    sum_lo = {result_SIDM_carry[0], result_0[19:0]} + {1'b0, result_1[19:0]};
    sum_hi = {result_SIDM_carry[1], result_0[31:20]} + {1'b0, result_1[31:20]};
    c_v0   = '0;
    c_v1   = '0;
    case (mode)
      MODE_16X16:
        c_v0 = sext ? ACC_W'($signed(sum_00)) : ACC_W'(sum_00);
      MODE_SUM_16X8:
        c_v0 = sext ? ACC_W'($signed(sum_01[32:8])) : ACC_W'(sum_01[32:8]);
      MODE_DUAL_8X4: begin
        // Low and high segments are summed separately so no carry crosses bit 19/20.
        c_v0 = sext ? ACC_W'($signed(sum_lo[20:8])) : ACC_W'(sum_lo[20:8]);
        c_v1 = sext ? ACC_W'($signed(sum_hi))       : ACC_W'(sum_hi);
      end
      default: ;
    endcase
  end

  // S2 only stalls when the beat in S1 would overwrite a total still waiting downstream.
  assign s2_mismatch = frame_open && !s1_first && (s1_mode != frame_mode);
  assign s2_take     = s1_valid && !s2_mismatch;
  assign s2_drop     = s1_valid && s2_mismatch;
  assign s2_stall    = s2_take && s1_last && out_valid && !out_ready;
  assign s2_start    = s1_first || !frame_open;

  assign s1_advance  = !s1_valid || !s2_stall;
  assign in_ready    = !reset && s1_advance;
  assign in_accept   = in_valid && in_ready;

  assign next_acc0   = s2_start ? s1_v0 : acc0 + s1_v0;
  assign next_acc1   = s2_start ? s1_v1 : acc1 + s1_v1;
  assign next_count  = s2_start ? COUNT_W'(1) : count + COUNT_W'(1);

  // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_first   <= 1'b0;
      s1_last    <= 1'b0;
      s1_mode    <= MODE_16X16;
      s1_v0      <= '0;
      s1_v1      <= '0;
      frame_open <= 1'b0;
      frame_mode <= MODE_16X16;
      acc0       <= '0;
      acc1       <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_lane0  <= '0;
      out_lane1  <= '0;
      out_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (s1_advance) begin
        s1_valid <= in_accept && (mode != MODE_ILLEGAL);
        s1_first <= in_first;
        s1_last  <= in_last;
        s1_mode  <= mode;
        s1_v0    <= c_v0;
        s1_v1    <= c_v1;
      end

      if ((in_accept && mode == MODE_ILLEGAL) || s2_drop)
        err_sticky <= 1'b1;

      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (s2_take && !s2_stall) begin
        if (s1_last) begin
          out_valid  <= 1'b1;
          out_lane0  <= next_acc0;
          out_lane1  <= next_acc1;
          out_count  <= next_count;
          frame_open <= 1'b0;
        end else begin
          acc0       <= next_acc0;
          acc1       <= next_acc1;
          count      <= next_count;
          frame_open <= 1'b1;
          if (s2_start)
            frame_mode <= s1_mode;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_partial_result_accumulator.sv
// Scoreboard bench: the driver feeds an arithmetic frame model on every accepted beat,
// a monitor pops expected totals on each output handshake and checks hold stability.
module tb_mult_partial_result_accumulator;

  localparam int ACC_W   = 48;
  localparam int COUNT_W = 16;
  localparam logic [63:0] ACC_MASK = (64'd1 << ACC_W) - 64'd1;
  localparam logic [63:0] CNT_MASK = (64'd1 << COUNT_W) - 64'd1;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid, in_ready, in_first, in_last;
  logic [1:0]         mode;
  logic               a_sign, b_sign;
  logic [31:0]        result_0, result_1;
  logic [1:0]         result_SIDM_carry;
  logic               out_valid, out_ready;
  logic [ACC_W-1:0]   out_lane0, out_lane1;
  logic [COUNT_W-1:0] out_count;
  logic               err_sticky;

  mult_partial_result_accumulator #(.ACC_W(ACC_W), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .mode(mode), .a_sign(a_sign), .b_sign(b_sign),
    .result_0(result_0), .result_1(result_1), .result_SIDM_carry(result_SIDM_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lane0(out_lane0), .out_lane1(out_lane1), .out_count(out_count),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] lane0;
    logic [63:0] lane1;
    logic [63:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   auto_release = 1'b0;

  // Reference frame state
  bit          m_open;
  logic [1:0]  m_mode;
  logic [63:0] m_acc0, m_acc1, m_count;
  bit          m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ext(input logic [63:0] t, input int w, input bit sg);
    if (sg && ((t >> (w - 1)) & 64'd1) != 0) return (t - (64'd1 << w)) & ACC_MASK;
    return t;
  endfunction

  function automatic void lane_values(input logic [1:0] md, input bit sg,
                                      input logic [31:0] r0, input logic [31:0] r1,
                                      input logic [1:0] cy,
                                      output logic [63:0] v0, output logic [63:0] v1);
    logic [63:0] a0, a1, c0, c1, t, lo, hi;
    a0 = 64'(r0);
    a1 = 64'(r1);
    c0 = 64'(cy[0]);
    c1 = 64'(cy[1]);
    v0 = 0;
    v1 = 0;
    case (md)
      2'd0: v0 = ext((a0 + a1) % (64'd1 << 32), 32, sg);
      2'd1: begin
        t  = ((c1 << 32) + a0 + a1) % (64'd1 << 33);
        v0 = ext(t / 256, 25, sg);
      end
      2'd2: begin
        lo = ((c0 << 20) + (a0 % (64'd1 << 20)) + (a1 % (64'd1 << 20))) % (64'd1 << 21);
        hi = ((c1 << 12) + (a0 >> 20) + (a1 >> 20)) % (64'd1 << 13);
        v0 = ext(lo / 256, 13, sg);
        v1 = ext(hi, 13, sg);
      end
      default: ;
    endcase
  endfunction

  task automatic model_beat(input logic [1:0] md, input bit sg, input logic [31:0] r0,
                            input logic [31:0] r1, input logic [1:0] cy,
                            input bit fst, input bit lst);
    logic [63:0] v0, v1;
    bit start;
    exp_t e;
    lane_values(md, sg, r0, r1, cy, v0, v1);
    if (md == 2'd3 || (m_open && !fst && md != m_mode)) begin
      m_err = 1'b1;
      return;
    end
    start   = fst || !m_open;
    m_acc0  = start ? v0 : (m_acc0 + v0) & ACC_MASK;
    m_acc1  = start ? v1 : (m_acc1 + v1) & ACC_MASK;
    m_count = start ? 64'd1 : (m_count + 64'd1) & CNT_MASK;
    if (start) m_mode = md;
    m_open = !lst;
    if (lst) begin
      e.lane0 = m_acc0;
      e.lane1 = m_acc1;
      e.count = m_count;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_reset();
    m_open  = 1'b0;
    m_mode  = 2'd0;
    m_acc0  = 0;
    m_acc1  = 0;
    m_count = 0;
    m_err   = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic send(input logic [1:0] md, input bit as, input bit bs, input logic [31:0] r0,
                      input logic [31:0] r1, input logic [1:0] cy, input bit fst, input bit lst,
                      output int waits);
    in_valid = 1'b1; mode = md; a_sign = as; b_sign = bs;
    result_0 = r0; result_1 = r1; result_SIDM_carry = cy;
    in_first = fst; in_last = lst;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 64) begin
      @(posedge clk); #1;
      waits++;
      if (auto_release && waits >= 3) out_ready = 1'b1;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      return;
    end
    model_beat(md, as | bs, r0, r1, cy, fst, lst);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops on every handshake and checks that a stalled total does not move.
  initial begin
    bit          hold;
    logic [63:0] h0, h1, hc;
    exp_t        e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_lane0", 64'(out_lane0), h0);
          check("hold_lane1", 64'(out_lane1), h1);
          check("hold_count", 64'(out_count), hc);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("lane0", 64'(out_lane0), e.lane0);
            check("lane1", 64'(out_lane1), e.lane1);
            check("count", 64'(out_count), e.count);
          end
        end
        hold = out_valid && !out_ready;
        h0 = 64'(out_lane0);
        h1 = 64'(out_lane1);
        hc = 64'(out_count);
      end
    end
  end

  initial begin
    int w;
    bit fst, lst;
    logic [1:0] cur_mode, md;

    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; mode = 2'd0;
    a_sign = 1'b0; b_sign = 1'b0; result_0 = '0; result_1 = '0; result_SIDM_carry = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_lane0", 64'(out_lane0), 64'd0);
    check("rst_lane1", 64'(out_lane1), 64'd0);
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_err", 64'(err_sticky), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 1: mode 00 single beat, with T+2 latency
    send(2'd0, 0, 0, 32'h0000_1234, 32'h0001_0000, 2'b00, 1, 1, w);
    @(negedge clk);
    check("latency_t1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_t2", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // 2: mode 01 unsigned and signed with carry into the top
    send(2'd1, 0, 0, 32'h0000_0100, 32'h0000_0200, 2'b00, 1, 1, w);
    send(2'd1, 1, 0, 32'hFFFF_FF00, 32'h0000_0000, 2'b10, 1, 1, w);

    // 3: mode 10 dual lanes, then a low-segment carry-out
    send(2'd2, 0, 0, 32'h0050_0A00, 32'h0030_0600, 2'b00, 1, 1, w);
    send(2'd2, 0, 0, 32'h000F_FF00, 32'h0000_0100, 2'b00, 1, 1, w);
    send(2'd2, 0, 1, 32'h000F_FF00, 32'h0000_0100, 2'b01, 1, 1, w);

    // 4: multi-beat accumulation and modular wrap
    send(2'd0, 0, 0, 32'd1, 32'd0, 2'b00, 1, 0, w);
    send(2'd0, 0, 0, 32'd2, 32'd0, 2'b00, 0, 0, w);
    send(2'd0, 0, 0, 32'd3, 32'd0, 2'b00, 0, 1, w);
    send(2'd0, 1, 0, 32'hFFFF_FFFF, 32'd0, 2'b00, 1, 0, w);
    send(2'd0, 0, 0, 32'd1, 32'd0, 2'b00, 0, 1, w);
    drain("drain_directed");

    // 5: downstream stall while the next frame streams in
    out_ready = 1'b0;
    send(2'd0, 0, 0, 32'd10, 32'd0, 2'b00, 1, 0, w);
    send(2'd0, 0, 0, 32'd20, 32'd0, 2'b00, 0, 0, w);
    send(2'd0, 0, 0, 32'd30, 32'd0, 2'b00, 0, 1, w);
    send(2'd2, 0, 0, 32'h0010_0100, 32'h0020_0200, 2'b00, 1, 0, w);
    check("stall_b1_waits", 64'(w), 64'd0);
    send(2'd2, 0, 0, 32'h0010_0100, 32'h0020_0200, 2'b00, 0, 0, w);
    check("stall_b2_waits", 64'(w), 64'd0);
    send(2'd2, 0, 0, 32'h0010_0100, 32'h0020_0200, 2'b00, 0, 1, w);
    check("stall_b3_waits", 64'(w), 64'd0);
    @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("drain_stall");

    // 6: illegal mode, mid-frame mode change, reset mid-frame
    send(2'd3, 0, 0, 32'd5, 32'd5, 2'b00, 1, 1, w);
    idle(3);
    check("err_illegal", 64'(err_sticky), 64'(m_err));
    check("illegal_no_output", 64'(out_valid), 64'd0);
    send(2'd0, 0, 0, 32'd7, 32'd0, 2'b00, 1, 0, w);
    send(2'd1, 0, 0, 32'h1000, 32'd0, 2'b00, 0, 0, w);
    send(2'd0, 0, 0, 32'd8, 32'd0, 2'b00, 0, 1, w);
    drain("drain_mismatch");
    check("err_mismatch", 64'(err_sticky), 64'd1);
    send(2'd0, 0, 0, 32'd100, 32'd0, 2'b00, 1, 0, w);
    send(2'd0, 0, 0, 32'd200, 32'd0, 2'b00, 0, 0, w);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_lane0", 64'(out_lane0), 64'd0);
    check("midrst_lane1", 64'(out_lane1), 64'd0);
    check("midrst_count", 64'(out_count), 64'd0);
    check("midrst_err", 64'(err_sticky), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    idle(4);
    check("midrst_idle_valid", 64'(out_valid), 64'd0);
    send(2'd0, 0, 0, 32'd9, 32'd0, 2'b00, 0, 1, w);
    drain("drain_after_reset");

    // Randomised frames with random backpressure
    auto_release = 1'b1;
    cur_mode = 2'd0;
    for (int i = 0; i < 400; i++) begin
      fst = ($urandom_range(0, 7) == 0);
      lst = ($urandom_range(0, 3) == 0);
      md  = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(0, 3)) : cur_mode;
      out_ready = ($urandom_range(0, 3) != 0);
      send(md, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           2'($urandom_range(0, 3)), fst, lst, w);
      if (lst) cur_mode = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    drain("drain_random");
    idle(3);
    check("err_final", 64'(err_sticky), 64'(m_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
